// File: rtl/bcd_addsub_calc.sv
// Multi-digit BCD adder/subtractor with button editing and a multiplexed
// common-anode 7-segment scanner. Arithmetic is digit-serial, LSD first.
module bcd_addsub_calc #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 4,
  localparam int unsigned CW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_inc_a,
  input  logic                    btn_inc_b,
  input  logic                    btn_next,
  input  logic                    mode_select,
  input  logic                    btn_equals,
  input  logic [1:0]              view,
  output logic                    busy,
  output logic                    done,
  output logic [4*(DIGITS+1)-1:0] result_bcd,
  output logic                    result_neg,
  output logic [CW-1:0]           cursor,
  output logic [DIGITS+1:0]       anode,
  output logic [6:0]              seg7
);

  localparam int unsigned OW = 4 * DIGITS;
  localparam int unsigned RW = 4 * (DIGITS + 1);
  localparam int unsigned PW = $clog2(DIGITS + 2);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StCalc, StFin, StNeg, StDone} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] a_q, a_d, b_q, b_d;
  logic [OW-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
  logic [CW-1:0] cursor_q, cursor_d, cnt_q, cnt_d;
  logic          carry_q, carry_d, sub_q, sub_d;
  logic [RW-1:0] res_q, res_d;
  logic          neg_q, neg_d;
  logic          inc_a_q, inc_b_q, next_q, eq_q;
  logic          inc_a_e, inc_b_e, next_e, eq_e;
  logic [SW-1:0] scan_q;
  logic [PW-1:0] pos_q;
  logic [4:0]    sum;
  logic [3:0]    bop;

  // Returns {carry_out, digit} for a single decimal digit sum.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign inc_a_e = btn_inc_a & ~inc_a_q;
  assign inc_b_e = btn_inc_b & ~inc_b_q;
  assign next_e  = btn_next & ~next_q;
  assign eq_e    = btn_equals & ~eq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      res_q    <= '0;
      neg_q    <= 1'b0;
      inc_a_q  <= 1'b0;
      inc_b_q  <= 1'b0;
      next_q   <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      res_q    <= res_d;
      neg_q    <= neg_d;
      inc_a_q  <= btn_inc_a;
      inc_b_q  <= btn_inc_b;
      next_q   <= btn_next;
      eq_q     <= btn_equals;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    res_d    = res_q;
    neg_d    = neg_q;
    sum      = '0;
    bop      = '0;
    unique case (state_q)
      StIdle: begin
        // Increments address the digit under the cursor before it advances.
        for (int i = 0; i < DIGITS; i++) begin
          if (cursor_q == CW'(i)) begin
            if (inc_a_e) a_d[4*i +: 4] = inc_digit(a_q[4*i +: 4]);
            if (inc_b_e) b_d[4*i +: 4] = inc_digit(b_q[4*i +: 4]);
          end
        end
        if (next_e) cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + 1'b1;
        if (eq_e) begin
          opa_d   = a_q;
          opb_d   = b_q;
          sub_d   = mode_select;
          carry_d = mode_select;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        bop   = sub_q ? 4'd9 - opb_q[3:0] : opb_q[3:0];
        sum   = digit_add(opa_q[3:0], bop, carry_q);
        opa_d = opa_q >> 4;
        opb_d = opb_q >> 4;
        acc_d = acc_q >> 4;
        acc_d[OW-4 +: 4] = sum[3:0];
        carry_d = sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) state_d = StFin;
      end
      StFin: begin
        if (!sub_q || carry_q) begin
          res_d   = {3'b000, carry_q & ~sub_q, acc_q};
          neg_d   = 1'b0;
          state_d = StDone;
        end else begin
          // A < B: ten's-complement the intermediate to get the magnitude.
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = StNeg;
        end
      end
      StNeg: begin
        sum   = digit_add(4'd9 - acc_q[3:0], 4'd0, carry_q);
        acc_d = acc_q >> 4;
        acc_d[OW-4 +: 4] = sum[3:0];
        carry_d = sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          res_d   = {4'b0000, acc_d};
          neg_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q == StCalc) || (state_q == StFin) || (state_q == StNeg);
  assign done       = (state_q == StDone);
  assign result_bcd = res_q;
  assign result_neg = neg_q;
  assign cursor     = cursor_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= '0;
      pos_q  <= '0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      pos_q  <= (pos_q == PW'(DIGITS + 1)) ? '0 : pos_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  logic [RW-1:0] shown;
  logic [3:0]    code;

  // code 4'hA is the minus sign, 4'hF is blank.
  always_comb begin
    anode = '0;
    for (int i = 0; i < DIGITS + 2; i++) anode[i] = (pos_q == PW'(i));
    shown = view[1] ? res_q : RW'(view[0] ? b_q : a_q);
    code  = 4'hF;
    for (int i = 0; i <= DIGITS; i++) begin
      if (pos_q == PW'(i) && (view[1] || i < DIGITS)) code = shown[4*i +: 4];
    end
    if (pos_q == PW'(DIGITS + 1) && view[1] && neg_q) code = 4'hA;
    case (code)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      4'hA:    seg7 = 7'b0000001;
      default: seg7 = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_bcd_addsub_calc.sv
// Randomised bench for bcd_addsub_calc: a decimal reference model feeds a
// scoreboard of expected results that a separate monitor checks on done.
module tb_bcd_addsub_calc;
  localparam int D  = 2;
  localparam int SD = 4;
  localparam int RW = 4 * (D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_inc_a = 1'b0, btn_inc_b = 1'b0, btn_next = 1'b0;
  logic          mode_select = 1'b0, btn_equals = 1'b0;
  logic [1:0]    view = 2'd0;
  logic          busy, done, result_neg;
  logic [RW-1:0] result_bcd;
  logic [0:0]    cursor;
  logic [D+1:0]  anode;
  logic [6:0]    seg7;

  bcd_addsub_calc #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .btn_inc_a(btn_inc_a), .btn_inc_b(btn_inc_b),
    .btn_next(btn_next), .mode_select(mode_select), .btn_equals(btn_equals),
    .view(view), .busy(busy), .done(done), .result_bcd(result_bcd),
    .result_neg(result_neg), .cursor(cursor), .anode(anode), .seg7(seg7)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [RW-1:0] res;
    logic          neg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, cyc = 0, done_count = 0;
  int   am[D], bm[D];
  int   cur = 0, last_res = 0;
  bit   last_neg = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected result and cycle.
  initial forever begin
    @(negedge clk);
    if (done) begin
      done_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || result_bcd !== mon_e.res || result_neg !== mon_e.neg) begin
          errors++;
          $display("FAIL result: got cyc %0d bcd %0h neg %0b, required cyc %0d bcd %0h neg %0b",
                   cyc, result_bcd, result_neg, mon_e.cyc, mon_e.res, mon_e.neg);
        end
      end
    end
  end

  function automatic int val(input int d[D]);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + d[i];
    return v;
  endfunction

  function automatic logic [RW-1:0] to_bcd(input int v);
    logic [RW-1:0] r = '0;
    int            x = v;
    for (int i = 0; i <= D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  10: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int p);
    int x = last_res;
    if (view[1]) begin
      if (p > D) return last_neg ? seg_of(10) : seg_of(-1);
      for (int i = 0; i < p; i++) x = x / 10;
      return seg_of(x % 10);
    end
    if (p >= D) return seg_of(-1);
    return seg_of(view[0] ? bm[p] : am[p]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mask(input logic [2:0] m, input int hold, input bit model);
    btn_inc_a = m[0];
    btn_inc_b = m[1];
    btn_next  = m[2];
    repeat (hold) tick();
    btn_inc_a = 1'b0;
    btn_inc_b = 1'b0;
    btn_next  = 1'b0;
    tick();
    if (model) begin
      if (m[0]) am[cur] = (am[cur] + 1) % 10;
      if (m[1]) bm[cur] = (bm[cur] + 1) % 10;
      if (m[2]) cur = (cur + 1) % D;
    end
    chk("cursor", 32'(cursor), cur);
  endtask

  task automatic set_val(input bit which_b, input int target);
    int p = 1;
    for (int i = 0; i < D; i++) begin
      while (cur != i) press_mask(3'b100, 1, 1'b1);
      while ((which_b ? bm[i] : am[i]) != (target / p) % 10)
        press_mask(which_b ? 3'b010 : 3'b001, 1, 1'b1);
      p = p * 10;
    end
  endtask

  task automatic calc(input bit mode, input bit poke);
    int   a = val(am), b = val(bm), diff, start;
    bit   neg = 1'b0;
    exp_t e;
    if (!mode) diff = a + b;
    else begin
      diff = a - b;
      neg  = diff < 0;
      if (neg) diff = -diff;
    end
    mode_select = mode;
    btn_equals  = 1'b1;
    e.cyc = cyc + (neg ? 2 * D + 2 : D + 2);
    e.res = to_bcd(diff);
    e.neg = neg;
    sb.push_back(e);
    start = done_count;
    tick();
    btn_equals  = 1'b0;
    chk("busy_in_calc", 32'(busy), 1);
    mode_select = 1'($urandom_range(0, 1));
    if (poke) begin
      btn_inc_a  = 1'b1;
      btn_next   = 1'b1;
      btn_equals = 1'b1;
      tick();
      btn_inc_a  = 1'b0;
      btn_next   = 1'b0;
      btn_equals = 1'b0;
    end
    for (int k = 0; k < 40 && done_count == start; k++) tick();
    if (done_count == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 40 cycles, required one");
      sb.delete();
    end
    last_res = diff;
    last_neg = neg;
  endtask

  task automatic scan_check();
    logic [D+1:0] prev = '0;
    bit           found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (anode == 1 && prev == (1 << (D + 1))) found = 1'b1;
      prev = anode;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_wrap: got no wrap to position 0, required one");
    end
    for (int k = 0; k < SD * (D + 2); k++) begin
      chk("anode", 32'(anode), 1 << (k / SD));
      chk("seg7", 32'(seg7), 32'(exp_seg(k / SD)));
      tick();
    end
    chk("anode_wrap", 32'(anode), 1);
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      am[i] = 0;
      bm[i] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_anode", 32'(anode), 1);
    chk("rst_seg7", 32'(seg7), 32'(7'b1111110));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result_bcd), 0);
    chk("rst_neg", 32'(result_neg), 0);
    chk("rst_cursor", 32'(cursor), 0);

    set_val(1'b0, 47);
    set_val(1'b1, 85);
    calc(1'b0, 1'b0);
    calc(1'b1, 1'b0);
    set_val(1'b0, 85);
    set_val(1'b1, 47);
    calc(1'b1, 1'b0);
    set_val(1'b0, 0);
    set_val(1'b1, 0);
    calc(1'b1, 1'b0);

    // 9 wraps to 0 without touching the neighbour; long hold counts once.
    set_val(1'b0, 19);
    while (cur != 0) press_mask(3'b100, 1, 1'b1);
    press_mask(3'b001, 1, 1'b1);
    calc(1'b0, 1'b0);
    press_mask(3'b001, 20, 1'b1);
    press_mask(3'b111, 1, 1'b1);
    calc(1'b0, 1'b1);

    // Reset in the second CALC cycle: no done, everything cleared.
    mode_select = 1'b1;
    btn_equals  = 1'b1;
    tick();
    btn_equals = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result_bcd), 0);
    chk("midrst_neg", 32'(result_neg), 0);
    chk("midrst_cursor", 32'(cursor), 0);
    for (int i = 0; i < D; i++) begin
      am[i] = 0;
      bm[i] = 0;
    end
    cur = 0;
    repeat (D + 4) tick();
    calc(1'b0, 1'b0);

    set_val(1'b0, 47);
    set_val(1'b1, 85);
    calc(1'b1, 1'b0);
    view = 2'd2;
    scan_check();
    view = 2'd0;
    scan_check();

    for (int it = 0; it < 25; it++) begin
      for (int n = $urandom_range(0, 6); n > 0; n--)
        press_mask(3'($urandom_range(1, 7)), $urandom_range(1, 3), 1'b1);
      calc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    view = 2'd3;
    scan_check();

    repeat (4) tick();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_calc.md
Name: bcd_addsub_calc

Overview:
Parametrised multi-digit BCD adder/subtractor core for the 7-segment calculator. Operands A and B are edited digit by digit through synchronous button strobes. A digit-serial FSM computes A+B or A−B as a sign-magnitude BCD result. A built-in scanner time-multiplexes the selected value onto a common-anode 7-segment display.

Parameters:
DIGITS, 2, BCD digits per operand (legal range 1..4)
SCAN_DIV, 4, clk cycles each display position is held (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_inc_a  input  1  level; rising edge increments A digit at cursor
btn_inc_b  input  1  level; rising edge increments B digit at cursor
btn_next  input  1  level; rising edge advances cursor
mode_select  input  1  0 = add, 1 = subtract (A−B)
btn_equals  input  1  level; rising edge starts calculation
view  input  2  0 = show A, 1 = show B, 2/3 = show result
busy  output  1  high while calculation in progress
done  output  1  one-cycle pulse, result updated
result_bcd  output  4*(DIGITS+1)  result magnitude, digit 0 in LSBs
result_neg  output  1  result sign
cursor  output  clog2(DIGITS) (min 1)  current digit index
anode  output  DIGITS+2  one-hot, active high, bit 0 = rightmost
seg7  output  7  segments ABCDEFG, active high

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. It has priority over all other inputs.
- Reset state:
  - A = 0, B = 0, cursor = 0.
  - result_bcd = 0, result_neg = 0, busy = 0, done = 0.
  - FSM in IDLE.
  - Edge-detect history registers = 0.
  - anode = one-hot bit 0, scan counter = 0.
- Edge detection: every button input is registered once. edge = in & ~in_q. A held button yields exactly one edge.
- Editing (IDLE only):
  - btn_next edge: cursor+1, wraps DIGITS−1 → 0.
  - btn_inc_a / btn_inc_b edge: increments the addressed digit 0..9. 9 wraps to 0 with no carry into the neighbouring digit.
  - Simultaneous inc_a, inc_b and next edges in one cycle all take effect. Increments use the pre-advance cursor.
- While busy: all edit and equals edges are discarded (not queued).
- FSM states:
  - IDLE → CALC on equals edge. At that edge, A, B and mode_select are latched and the carry is initialised (add: c=0; sub: c=1).
  - CALC: DIGITS cycles, one digit per cycle, LSD first.
    - add: s = a+b+c.
    - sub: s = a+(9−b)+c.
    - If s > 9: digit = s−10 and c = 1; else digit = s and c = 0.
  - FIN: one cycle.
    - add: digit DIGITS = c, sign +.
    - sub with c = 1: digit DIGITS = 0, sign +, go to DONE.
    - sub with c = 0: go to NEG.
  - NEG: DIGITS cycles, ten's complement of the intermediate. Digit-serial s = (9−r)+c with initial c = 1. Digit DIGITS = 0, sign −.
  - DONE: one cycle, then IDLE.
- Outputs during calculation:
  - result_bcd and result_neg are updated only on entry to DONE. They hold their value otherwise.
  - done = 1 exactly in the DONE cycle.
  - busy = 1 in CALC, FIN and NEG. busy = 0 in DONE.
- Latency: with the equals edge seen in cycle t, done is high in cycle t+DIGITS+2 for add or non-negative subtract, and t+2*DIGITS+2 for negative subtract.
- Zero result: 0−0 gives result 0, result_neg = 0. Negative zero is never produced.
- Mode changes mid-operation have no effect on the operation in progress.
- Reset mid-operation: immediate IDLE. No done pulse. Result cleared.
- Scanner:
  - The counter counts SCAN_DIV cycles, then anode rotates left one position, wrapping DIGITS+1 → 0.
  - seg7 is combinational from the current anode position and the current data.
- Per-position digit codes:
  - view 0 / 1: positions 0..DIGITS−1 show the operand digit. Positions DIGITS..DIGITS+1 are blank.
  - view 2 / 3: positions 0..DIGITS show result digits. Position DIGITS+1 shows '-' if result_neg, else blank.
  - No leading-zero suppression.
- Segment encoding: 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011, '-' = 0000001, blank = 0000000.

Test Plan:
1. Reset, DIGITS=2, view=0 → A=B=0, anode=0001, seg7=1111110, busy=0, result_bcd=0x000.
2. Enter A=47 (7 inc_a, next, 4 inc_a), B=85, mode 0, equals edge at t → done high at t+4 only, result_bcd=0x132, result_neg=0.
3. A=47, B=85, mode 1 → done at t+6, result_bcd=0x038, result_neg=1. With A=85, B=47 → done at t+4, 0x038, result_neg=0. With A=00, B=00 → 0x000, result_neg=0.
4. Digit at 9 plus inc → 0, neighbour digit unchanged. Cursor wraps 1→0. Button held 20 cycles → one increment. Equals and inc edges during busy → ignored, result equals the first computation.
5. Reset asserted in second CALC cycle → busy=0 next cycle, no done, result_bcd=0, A=B=0.
6. SCAN_DIV=4, result −038, view=2 → positions 0..3 show 8, 3, 0, '-' (1111111, 1111001, 1111110, 0000001), each for 4 cycles, then wrap to position 0.
